// File: rtl/dc_offset_subtract_pkg.sv
// Shared constants and FSM state type for the DC offset subtractor.
// The optional saturating reduction is selected with DC_SUB_SAT_EN.
package lia_dc_pkg;

  localparam int NUM_CH   = 4;
  localparam int SAMPLE_W = 16;

  localparam int CH_05SIN = 0;
  localparam int CH_05COS = 1;
  localparam int CH_6SIN  = 2;
  localparam int CH_6COS  = 3;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_OFS = 2'd1,
    RUN      = 2'd2
  } state_t;

endpackage

// File: rtl/dc_offset_subtract_lane.sv
// One channel: frozen offset register, widened subtract, then reduction to DATA_W.
// DC_SUB_SAT_EN selects clamping with a sticky saturation bit; otherwise the result wraps.
module dc_sub_lane
  import lia_dc_pkg::*;
#(
  parameter int DATA_W = SAMPLE_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              latch,
  input  logic              load,
  input  logic              emit,
  input  logic [DATA_W-1:0] ofs,
  input  logic [DATA_W-1:0] sample,
  output logic [DATA_W-1:0] out,
  output logic              sat
);

  logic [DATA_W-1:0] ofs_q;
  logic [DATA_W:0]   diff;
  logic [DATA_W-1:0] red;
  logic              clamp;

`ifdef DC_SUB_SAT_EN
  // Clamp when the sign bit and the top data bit of the widened difference disagree.
  always_comb begin
    red   = diff[DATA_W-1:0];
    clamp = 1'b0;
    if (diff[DATA_W] != diff[DATA_W-1]) begin
      clamp = 1'b1;
      red   = diff[DATA_W] ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}};
    end else begin
      clamp = 1'b0;
    end
  end
`else
  // Wrap mode keeps only the low bits; the guard bit is deliberately discarded.
  assign red   = diff[DATA_W-1:0];
  assign clamp = 1'b0 & diff[DATA_W];
`endif

  // Offset latch, stage-1 difference and stage-2 output/sticky flag.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      ofs_q <= '0;
      diff  <= '0;
      out   <= '0;
      sat   <= 1'b0;
    end else begin
      if (latch) ofs_q <= ofs;
      if (load)  diff  <= {sample[DATA_W-1], sample} - {ofs_q[DATA_W-1], ofs_q};
      if (emit) begin
        out <= red;
        sat <= sat | clamp;
      end
    end
  end

endmodule

// File: rtl/dc_offset_subtract.sv
// Removes latched DC offsets from four demodulated channels with fixed 2-cycle latency.
// Build with DC_SUB_SAT_EN to clamp results instead of wrapping.
module dc_offset_subtract
  import lia_dc_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              ofs_valid,
  input  logic [DATA_W-1:0] ofs_05sin,
  input  logic [DATA_W-1:0] ofs_05cos,
  input  logic [DATA_W-1:0] ofs_6sin,
  input  logic [DATA_W-1:0] ofs_6cos,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_05sin,
  input  logic [DATA_W-1:0] in_05cos,
  input  logic [DATA_W-1:0] in_6sin,
  input  logic [DATA_W-1:0] in_6cos,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_05sin,
  output logic [DATA_W-1:0] out_05cos,
  output logic [DATA_W-1:0] out_6sin,
  output logic [DATA_W-1:0] out_6cos,
  output logic [CNT_W-1:0]  out_count,
  output logic              running,
  output logic [3:0]        sat_flag
);

  state_t state, state_next;
  logic   latch, accept, v1;

  logic [NUM_CH-1:0][DATA_W-1:0] ofs_bus, in_bus, out_bus;
  logic [NUM_CH-1:0]             sat_bus;

  // Next state plus latch/accept strobes; start overrides everything but rst.
  always_comb begin
    state_next = state;
    latch      = 1'b0;
    accept     = 1'b0;
    if (start) begin
      state_next = WAIT_OFS;
    end else begin
      case (state)
        IDLE:     state_next = IDLE;
        WAIT_OFS: begin
          if (ofs_valid) begin
            latch      = 1'b1;
            state_next = RUN;
          end else begin
            state_next = WAIT_OFS;
          end
        end
        RUN: begin
          accept     = in_valid;
          state_next = RUN;
        end
        default:  state_next = IDLE;
      endcase
    end
  end

  // State register and registered running indicator.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      running <= 1'b0;
    end else begin
      state   <= state_next;
      running <= (state_next == RUN);
    end
  end

  // Valid pipeline and saturating output counter; start discards in-flight samples.
  always_ff @(posedge clk) begin
    if (rst || start) begin
      v1        <= 1'b0;
      out_valid <= 1'b0;
      out_count <= '0;
    end else begin
      v1        <= accept;
      out_valid <= v1;
      if (v1 && (out_count != {CNT_W{1'b1}})) begin
        out_count <= out_count + {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end
  end

  assign ofs_bus[CH_05SIN] = ofs_05sin;
  assign ofs_bus[CH_05COS] = ofs_05cos;
  assign ofs_bus[CH_6SIN]  = ofs_6sin;
  assign ofs_bus[CH_6COS]  = ofs_6cos;
  assign in_bus[CH_05SIN]  = in_05sin;
  assign in_bus[CH_05COS]  = in_05cos;
  assign in_bus[CH_6SIN]   = in_6sin;
  assign in_bus[CH_6COS]   = in_6cos;

  for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_lane
    dc_sub_lane #(.DATA_W(DATA_W)) u_lane (
      .clk    (clk),
      .rst    (rst),
      .clear  (start),
      .latch  (latch),
      .load   (accept),
      .emit   (v1),
      .ofs    (ofs_bus[ch]),
      .sample (in_bus[ch]),
      .out    (out_bus[ch]),
      .sat    (sat_bus[ch])
    );
  end

  assign out_05sin = out_bus[CH_05SIN];
  assign out_05cos = out_bus[CH_05COS];
  assign out_6sin  = out_bus[CH_6SIN];
  assign out_6cos  = out_bus[CH_6COS];
  assign sat_flag  = sat_bus;

endmodule

// File: tb/tb_dc_offset_subtract.sv
// Scoreboard bench for dc_offset_subtract: random and directed stimulus, reference model
// computes in - offset arithmetically; a negedge monitor pops and compares each out_valid.
module tb_dc_offset_subtract;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        ofs_valid = 1'b0;
  logic [15:0] ofs_05sin = '0, ofs_05cos = '0, ofs_6sin = '0, ofs_6cos = '0;
  logic        in_valid = 1'b0;
  logic [15:0] in_05sin = '0, in_05cos = '0, in_6sin = '0, in_6cos = '0;
  logic        out_valid;
  logic [15:0] out_05sin, out_05cos, out_6sin, out_6cos;
  logic [31:0] out_count;
  logic        running;
  logic [3:0]  sat_flag;

  dc_offset_subtract #(.DATA_W(16), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .start(start), .ofs_valid(ofs_valid),
    .ofs_05sin(ofs_05sin), .ofs_05cos(ofs_05cos), .ofs_6sin(ofs_6sin), .ofs_6cos(ofs_6cos),
    .in_valid(in_valid),
    .in_05sin(in_05sin), .in_05cos(in_05cos), .in_6sin(in_6sin), .in_6cos(in_6cos),
    .out_valid(out_valid),
    .out_05sin(out_05sin), .out_05cos(out_05cos), .out_6sin(out_6sin), .out_6cos(out_6cos),
    .out_count(out_count), .running(running), .sat_flag(sat_flag)
  );

  always #5 clk = ~clk;

  typedef logic [3:0][15:0] quad_t;
  typedef struct {
    quad_t       d;
    logic [31:0] cnt;
    logic [3:0]  sat;
    int          emit;
  } exp_t;
  typedef enum {M_IDLE, M_WAIT, M_RUN} mstate_t;

  exp_t        sb[$];
  int          vectors = 0;
  int          fails = 0;
  int          cyc = 0;
  bit          mon_en = 1'b0;
  mstate_t     m_state = M_IDLE;
  quad_t       m_ofs = '0;
  logic [31:0] m_cnt = '0;
  logic [3:0]  m_sat = '0;
  quad_t       zero4 = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic quad_t rnd4();
    quad_t q;
    for (int i = 0; i < 4; i++) q[i] = 16'($urandom);
    return q;
  endfunction

  // Drive one cycle of inputs, advance the reference model, wait for the capturing edge.
  task automatic step(input logic st, input logic ov, input quad_t o, input logic iv, input quad_t x);
    mstate_t nxt;
    exp_t    e;
    int      d;
    start = st; ofs_valid = ov; in_valid = iv;
    ofs_05sin = o[0]; ofs_05cos = o[1]; ofs_6sin = o[2]; ofs_6cos = o[3];
    in_05sin = x[0]; in_05cos = x[1]; in_6sin = x[2]; in_6cos = x[3];
    nxt = m_state;
    if (st) begin
      while (sb.size() > 0 && sb[$].emit > cyc) void'(sb.pop_back());
      m_cnt = '0; m_sat = '0; m_ofs = '0;
      nxt = M_WAIT;
    end else if (m_state == M_WAIT && ov) begin
      m_ofs = o;
      nxt = M_RUN;
    end else if (m_state == M_RUN && iv) begin
      for (int ch = 0; ch < 4; ch++) begin
        d = int'($signed(x[ch])) - int'($signed(m_ofs[ch]));
`ifdef DC_SUB_SAT_EN
        if (d > 32767) begin
          d = 32767; m_sat[ch] = 1'b1;
        end else if (d < -32768) begin
          d = -32768; m_sat[ch] = 1'b1;
        end
`endif
        e.d[ch] = d[15:0];
      end
      if (m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 32'd1;
      e.cnt = m_cnt; e.sat = m_sat; e.emit = cyc + 2;
      sb.push_back(e);
    end
    @(posedge clk); #1;
    m_state = nxt;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, zero4, 1'b0, zero4);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    while (sb.size() > 0 && sb[$].emit > cyc) void'(sb.pop_back());
    step(1'b0, 1'b0, zero4, 1'b0, zero4);
    m_state = M_IDLE; m_cnt = '0; m_sat = '0; m_ofs = '0;
    rst = 1'b0;
  endtask

  // Monitor: compare every presented output against the scoreboard head.
  always @(negedge clk) begin
    if (mon_en) begin
      chk("running", 64'(running), 64'(m_state == M_RUN));
      if (out_valid) begin
        if (sb.size() == 0) begin
          chk("unexpected_out_valid", 64'd1, 64'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("latency_cycle", 64'(cyc), 64'(e.emit));
          chk("out_05sin", 64'(out_05sin), 64'(e.d[0]));
          chk("out_05cos", 64'(out_05cos), 64'(e.d[1]));
          chk("out_6sin",  64'(out_6sin),  64'(e.d[2]));
          chk("out_6cos",  64'(out_6cos),  64'(e.d[3]));
          chk("out_count", 64'(out_count), 64'(e.cnt));
          chk("sat_flag",  64'(sat_flag),  64'(e.sat));
        end
      end
    end
  end

  quad_t o, x;

  initial begin
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    do_reset();
    mon_en = 1'b1;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_count", 64'(out_count), 64'd0);
    chk("rst_running",   64'(running),   64'd0);
    chk("rst_sat_flag",  64'(sat_flag),  64'd0);
    chk("rst_outs", {out_6cos, out_6sin, out_05cos, out_05sin}, 64'd0);

    // IDLE ignores samples
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, zero4, 1'b1, rnd4());

    // WAIT_OFS drops samples, including the one coincident with ofs_valid
    step(1'b1, 1'b0, zero4, 1'b0, zero4);
    for (int i = 0; i < 6; i++) step(1'b0, 1'b0, zero4, 1'b1, rnd4());
    chk("wait_count", 64'(out_count), 64'd0);
    o[0] = 16'd100; o[1] = 16'hFF38; o[2] = 16'd0; o[3] = 16'd5;
    step(1'b0, 1'b1, o, 1'b1, rnd4());
    x[0] = 16'd1100; x[1] = 16'hFF38; x[2] = 16'd7; x[3] = 16'd5;
    step(1'b0, 1'b0, zero4, 1'b1, x);
    idle(2);
    chk("t1_05sin", 64'(out_05sin), 64'd1000);
    chk("t1_05cos", 64'(out_05cos), 64'd0);
    chk("t1_6sin",  64'(out_6sin),  64'd7);
    chk("t1_6cos",  64'(out_6cos),  64'd0);
    chk("t1_count", 64'(out_count), 64'd1);

    // Offsets frozen in RUN
    o[0] = 16'd9; o[1] = 16'd9; o[2] = 16'd9; o[3] = 16'd9;
    for (int i = 0; i < 20; i++) step(1'b0, 1'b1, o, 1'($urandom_range(0, 1)), rnd4());

    // start one cycle after an accepted sample discards it
    step(1'b0, 1'b0, zero4, 1'b1, rnd4());
    step(1'b1, 1'b0, zero4, 1'b0, zero4);
    idle(4);
    chk("t5_count",   64'(out_count), 64'd0);
    chk("t5_running", 64'(running),   64'd0);
    chk("t5_sat",     64'(sat_flag),  64'd0);
    chk("t5_valid",   64'(out_valid), 64'd0);

    // Overflow case
    o = '0; o[0] = 16'hFC18;
    step(1'b0, 1'b1, o, 1'b0, zero4);
    x = '0; x[0] = 16'd32000;
    step(1'b0, 1'b0, zero4, 1'b1, x);
    idle(2);
`ifdef DC_SUB_SAT_EN
    chk("t2_05sin", 64'(out_05sin), 64'h7FFF);
    chk("t2_sat",   64'(sat_flag),  64'h1);
`else
    chk("t2_05sin", 64'(out_05sin), 64'h80E8);
    chk("t2_sat",   64'(sat_flag),  64'h0);
`endif

    // Random traffic with ignored offset updates
    for (int i = 0; i < 300; i++)
      step(1'b0, 1'($urandom_range(0, 3) == 0), rnd4(), 1'($urandom_range(0, 1)), rnd4());

    // 1000 back-to-back samples
    step(1'b1, 1'b0, zero4, 1'b0, zero4);
    step(1'b0, 1'b1, rnd4(), 1'b0, zero4);
    for (int i = 0; i < 1000; i++) step(1'b0, 1'b0, zero4, 1'b1, rnd4());
    idle(3);
    chk("b2b_count", 64'(out_count), 64'd1000);

    // Random restarts mixed with offsets and samples
    for (int i = 0; i < 400; i++)
      step(1'($urandom_range(0, 39) == 0), 1'($urandom_range(0, 3) == 0), rnd4(),
           1'($urandom_range(0, 1)), rnd4());

    // Counter saturation
    step(1'b1, 1'b0, zero4, 1'b0, zero4);
    step(1'b0, 1'b1, rnd4(), 1'b0, zero4);
    step(1'b0, 1'b0, zero4, 1'b1, rnd4());
    idle(3);
    force dut.out_count = 32'hFFFF_FFFE;
    #1;
    release dut.out_count;
    m_cnt = 32'hFFFF_FFFE;
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, zero4, 1'b1, rnd4());
    idle(3);
    chk("cnt_saturate", 64'(out_count), 64'hFFFF_FFFF);

    chk("sb_drained", 64'(sb.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
